// File: rtl/wavetable_pkg.sv
// ---------------------------------------------------------------------------
// wavetable_pkg
//   Shared types and constants for the wavetable BRAM writer slice.
//
//   wave_t   : waveform selector encoding (matches the wave_sel port value)
//   state_t  : writer sequencing states
//   BRAM_ADDR_INCREMENT_DEF : default byte stride between table words
//   AMPL_MAX : full-scale positive sample amplitude
//
//   Optional feature macro used by this slice: WT_SINE_EN
// ---------------------------------------------------------------------------
package wavetable_pkg;

  typedef enum logic [1:0] {
    SAW      = 2'd0,
    SQUARE   = 2'd1,
    TRIANGLE = 2'd2,
    SINE     = 2'd3
  } wave_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    WRITE  = 2'd2,
    NOTIFY = 2'd3
  } state_t;

  localparam int BRAM_ADDR_INCREMENT_DEF = 4;
  localparam int AMPL_MAX                = 32767;

  // Byte address of table word idx for a given stride, truncated to the
  // 32-bit BRAM address bus.
  function automatic logic [31:0] word_byte_addr(input logic [31:0] idx,
                                                 input int          stride);
    logic [31:0] s;
    s = 32'(stride);
    return idx * s;
  endfunction

endpackage

// File: rtl/wt_sine_quarter_lut.sv
// ---------------------------------------------------------------------------
// wt_sine_quarter_lut
//   Full-cycle sine sample generator built from a quarter-wave table of
//   NUM_WORDS/4+1 entries. The table is filled at elaboration; quadrant
//   folding (mirror for odd quadrants, negate for the second half) happens
//   here so the caller just supplies the table index.
//
//   Only compiled when WT_SINE_EN is defined.
//
//   Ports
//     BRAM_clk : clock
//     index    : table index 0..NUM_WORDS-1
//     sample   : registered signed sample, one cycle after index
// ---------------------------------------------------------------------------
`ifdef WT_SINE_EN
module wt_sine_quarter_lut
  import wavetable_pkg::*;
#(
  parameter int NUM_WORDS = 256
) (
  input  logic                         BRAM_clk,
  input  logic [$clog2(NUM_WORDS)-1:0] index,
  output logic signed [15:0]           sample
);

  localparam int    IDX_W = $clog2(NUM_WORDS);
  localparam int    K_W   = IDX_W - 2;
  localparam int    QTR   = NUM_WORDS / 4;
  localparam real   PI    = 3.14159265358979323846;

  // Quarter-wave values are all non-negative, so +0.5 then truncate rounds.
  function automatic logic [15:0] lut_entry(input int j);
    real ang;
    ang = 2.0 * PI * real'(j) / real'(NUM_WORDS);
    return 16'($rtoi(real'(AMPL_MAX) * $sin(ang) + 0.5));
  endfunction

  logic [15:0] rom [0:QTR];

  for (genvar j = 0; j <= QTR; j++) begin : g_rom
    assign rom[j] = lut_entry(j);
  end

  logic [1:0]        quad;
  logic [K_W-1:0]    k;
  logic [K_W:0]      rom_addr;
  logic signed [15:0] mag;

  assign quad = index[IDX_W-1 -: 2];
  assign k    = index[K_W-1:0];

  // Odd quadrants run the quarter table backwards: lut[N/4 - k].
  always_comb begin
    rom_addr = {1'b0, k};
    if (quad[0]) begin
      rom_addr = (K_W+1)'(QTR) - {1'b0, k};
    end
    mag = rom[rom_addr];
  end

  always_ff @(posedge BRAM_clk) begin
    sample <= quad[1] ? -mag : mag;
  end

endmodule
`endif

// File: rtl/wavetable_bram_writer.sv
// ---------------------------------------------------------------------------
// wavetable_bram_writer
//   Synthesises one full cycle of a saw / square / triangle / sine waveform,
//   NUM_WORDS samples long, writes it into the shared wavetable BRAM through
//   its write port, then pulses refresh so the downstream loader re-reads the
//   table. Everything runs in the BRAM_clk domain.
//
//   Optional feature macro: WT_SINE_EN
//     defined   : sine quarter-wave LUT is built, wave_sel=3 gives sine
//     undefined : no LUT, wave_sel=3 gives triangle; timing is identical
//
//   Parameters
//     NUM_WORDS           : table length, power of two, >= 8
//     BRAM_ADDR_INCREMENT : byte stride between consecutive words
//
//   Ports
//     BRAM_clk  : clock
//     rst       : synchronous active-high reset
//     start     : request a table write (only honoured in IDLE)
//     wave_sel  : 0 saw, 1 square, 2 triangle, 3 sine
//     atten     : arithmetic right-shift applied to each sample (0..15)
//     busy      : high from the cycle after start is accepted until done
//     done      : one-cycle pulse, coincident with refresh
//     refresh   : one-cycle pulse to the downstream loader
//     BRAM_addr : byte address
//     BRAM_din  : {16'h0000, sample}
//     BRAM_en   : BRAM enable
//     BRAM_we   : byte write enables, 4'hF or 4'h0
//     BRAM_rst  : BRAM reset, follows rst one cycle late
//
//   States
//     IDLE   | waiting for start, BRAM port quiet
//     PRIME  | sample 0 computed into the pipeline register, no write
//     WRITE  | one word written per cycle, next sample computed alongside
//     NOTIFY | refresh/done pulse, then back to IDLE
// ---------------------------------------------------------------------------
module wavetable_bram_writer
  import wavetable_pkg::*;
#(
  parameter int NUM_WORDS           = 256,
  parameter int BRAM_ADDR_INCREMENT = BRAM_ADDR_INCREMENT_DEF
) (
  input  logic        BRAM_clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  wave_sel,
  input  logic [3:0]  atten,
  output logic        busy,
  output logic        done,
  output logic        refresh,
  output logic [31:0] BRAM_addr,
  output logic [31:0] BRAM_din,
  output logic        BRAM_en,
  output logic [3:0]  BRAM_we,
  output logic        BRAM_rst
);

  localparam int               IDX_W    = $clog2(NUM_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [15:0]      AMPL_POS = 16'(AMPL_MAX);
  localparam logic [15:0]      AMPL_NEG = 16'(-AMPL_MAX);

  state_t             state;
  wave_t              wave_l;
  logic [3:0]         atten_l;

  // comp_idx is the index being computed this cycle; samp_idx is the index
  // of the sample sitting in the pipeline register (one cycle behind).
  logic [IDX_W-1:0]   comp_idx;
  logic [IDX_W-1:0]   samp_idx;
  logic signed [15:0] samp_reg;
  logic signed [15:0] samp_next;
  logic signed [15:0] sel_sample;
  logic signed [15:0] shifted;

  // -------------------------------------------------------------------------
  // Sample arithmetic for the index being computed
  // -------------------------------------------------------------------------
  logic [15:0] phase;
  logic [15:0] tri_q;

  assign phase = 16'(comp_idx) << (16 - IDX_W);
  assign tri_q = {phase[14:0], 1'b0};

  // All results fit in 16 bits, so modular 16-bit arithmetic is exact:
  // q - 32768 and 32767 - q both land in [-32768, 32767].
  always_comb begin
    samp_next = '0;
    case (wave_l)
      SAW:     samp_next = phase ^ 16'h8000;
      SQUARE:  samp_next = phase[15] ? AMPL_NEG : AMPL_POS;
      default: begin
        if (!phase[15]) begin
          samp_next = tri_q - 16'h8000;
        end else begin
          samp_next = 16'h7FFF - tri_q;
        end
      end
    endcase
  end

`ifdef WT_SINE_EN
  logic signed [15:0] sine_q;

  // LUT output is registered internally, so it lines up with samp_reg and
  // the pipeline stays one deep.
  wt_sine_quarter_lut #(
    .NUM_WORDS (NUM_WORDS)
  ) u_sine_lut (
    .BRAM_clk (BRAM_clk),
    .index    (comp_idx),
    .sample   (sine_q)
  );

  assign sel_sample = (wave_l == SINE) ? sine_q : samp_reg;
`else
  assign sel_sample = samp_reg;
`endif

  assign shifted = sel_sample >>> atten_l;

  // -------------------------------------------------------------------------
  // Sequencer with registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge BRAM_clk) begin
    if (rst) begin
      state     <= IDLE;
      wave_l    <= SAW;
      atten_l   <= '0;
      comp_idx  <= '0;
      samp_idx  <= '0;
      samp_reg  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      refresh   <= 1'b0;
      BRAM_addr <= '0;
      BRAM_din  <= '0;
      BRAM_en   <= 1'b0;
      BRAM_we   <= 4'h0;
      BRAM_rst  <= 1'b1;
    end else begin
      BRAM_rst <= 1'b0;
      done     <= 1'b0;
      refresh  <= 1'b0;
      BRAM_en  <= 1'b0;
      BRAM_we  <= 4'h0;

      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            wave_l   <= wave_t'(wave_sel);
            atten_l  <= atten;
            comp_idx <= '0;
            busy     <= 1'b1;
            state    <= PRIME;
          end
        end

        PRIME: begin
          samp_reg <= samp_next;
          samp_idx <= comp_idx;
          comp_idx <= comp_idx + IDX_W'(1);
          state    <= WRITE;
        end

        WRITE: begin
          BRAM_en   <= 1'b1;
          BRAM_we   <= 4'hF;
          BRAM_addr <= word_byte_addr(32'(samp_idx), BRAM_ADDR_INCREMENT);
          BRAM_din  <= {16'h0000, shifted};
          // Past the last word comp_idx wraps; the stale sample it produces
          // is never written.
          samp_reg  <= samp_next;
          samp_idx  <= comp_idx;
          comp_idx  <= comp_idx + IDX_W'(1);
          if (samp_idx == LAST_IDX) begin
            state <= NOTIFY;
          end
        end

        NOTIFY: begin
          refresh <= 1'b1;
          done    <= 1'b1;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wavetable_bram_writer.sv
// ---------------------------------------------------------------------------
// tb_wavetable_bram_writer
//   Drives randomized and directed table requests into wavetable_bram_writer,
//   captures every BRAM write into a shadow table, and compares against a
//   closed-form waveform model.
// ---------------------------------------------------------------------------
module tb_wavetable_bram_writer;

  localparam int  N  = 256;
  localparam real PI = 3.14159265358979323846;

  logic        BRAM_clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  wave_sel;
  logic [3:0]  atten;
  logic        busy;
  logic        done;
  logic        refresh;
  logic [31:0] BRAM_addr;
  logic [31:0] BRAM_din;
  logic        BRAM_en;
  logic [3:0]  BRAM_we;
  logic        BRAM_rst;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:N-1];

  always #5 BRAM_clk = ~BRAM_clk;

  wavetable_bram_writer #(
    .NUM_WORDS           (N),
    .BRAM_ADDR_INCREMENT (4)
  ) dut (
    .BRAM_clk  (BRAM_clk),
    .rst       (rst),
    .start     (start),
    .wave_sel  (wave_sel),
    .atten     (atten),
    .busy      (busy),
    .done      (done),
    .refresh   (refresh),
    .BRAM_addr (BRAM_addr),
    .BRAM_din  (BRAM_din),
    .BRAM_en   (BRAM_en),
    .BRAM_we   (BRAM_we),
    .BRAM_rst  (BRAM_rst)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Waveform value straight from its mathematical definition over one cycle.
  function automatic logic [31:0] model(input int w, input int a, input int k);
    int  s;
    int  p;
    real x;
    int  wv;
    wv = w;
`ifndef WT_SINE_EN
    if (wv == 3) wv = 2;
`endif
    p = k * 65536 / N;
    s = 0;
    case (wv)
      0: s = p - 32768;
      1: s = (p < 32768) ? 32767 : -32767;
      2: s = (p < 32768) ? (2 * p - 32768) : (32767 - 2 * (p - 32768));
      default: begin
        x = 32767.0 * $sin(2.0 * PI * real'(k) / real'(N));
        if (x >= 0.0) s = $rtoi(x + 0.5);
        else          s = -$rtoi(-x + 0.5);
      end
    endcase
    s = s >>> a;
    return {16'h0000, 16'(s)};
  endfunction

  // One table request. poke_idx>=0 injects either a start+wave_sel change or
  // a reset when the write of that index is observed.
  task automatic run_table(input int w, input int a, input int poke_idx,
                           input bit do_rst, input int span);
    int ref_at;
    int nref;
    int nwr;
    bit rst_pending;
    ref_at = -1;
    nref = 0;
    nwr = 0;
    rst_pending = 0;
    for (int k = 0; k < N; k++) mem[k] = 32'hDEAD_BEEF;

    @(negedge BRAM_clk);
    start = 1'b1; wave_sel = 2'(w); atten = 4'(a);
    @(negedge BRAM_clk);
    // after edge 0: the latch must ignore further input changes
    start = 1'b0; wave_sel = 2'($urandom); atten = 4'($urandom);

    for (int i = 1; i <= span; i++) begin
      @(negedge BRAM_clk);
      start = 1'b0;
      if (rst_pending) begin
        chk("rst_en", 32'(BRAM_en), 0);
        chk("rst_we", 32'(BRAM_we), 0);
        chk("rst_bram_rst", 32'(BRAM_rst), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_refresh", 32'(refresh), 0);
        rst = 1'b0;
        rst_pending = 0;
      end
      if (i == 1) chk("busy_prime", 32'(busy), 1);
      if (ref_at > 0 && i == ref_at + 1) begin
        chk("busy_after", 32'(busy), 0);
        chk("done_after", 32'(done), 0);
      end
      if (BRAM_en) begin
        chk("we_write", 32'(BRAM_we), 32'hF);
        chk("addr_seq", BRAM_addr, 32'(4 * nwr));
        mem[(BRAM_addr >> 2) % N] = BRAM_din;
        if (poke_idx >= 0 && BRAM_addr == 32'(poke_idx * 4)) begin
          if (do_rst) begin
            rst = 1'b1;
            rst_pending = 1;
          end else begin
            start = 1'b1;
            wave_sel = 2'(w + 1);
          end
        end
        nwr++;
      end else begin
        chk("we_idle", 32'(BRAM_we), 0);
      end
      if (refresh) begin
        nref++;
        if (ref_at < 0) begin
          ref_at = i;
          chk("done_with_refresh", 32'(done), 1);
        end
      end
    end

    if (do_rst) begin
      chk("rst_refresh_cnt", 32'(nref), 0);
      chk("rst_partial_cnt", 32'(nwr), 32'(poke_idx + 1));
    end else begin
      chk("refresh_latency", 32'(ref_at), 32'(N + 2));
      chk("refresh_cnt", 32'(nref), 1);
      chk("write_cnt", 32'(nwr), 32'(N));
      for (int k = 0; k < N; k++)
        chk($sformatf("w%0d_a%0d_word%0d", w, a, k), mem[k], model(w, a, k));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; wave_sel = 2'd0; atten = 4'd0;
    repeat (3) @(negedge BRAM_clk);
    chk("reset_addr", BRAM_addr, 0);
    chk("reset_din", BRAM_din, 0);
    chk("reset_en", 32'(BRAM_en), 0);
    chk("reset_we", 32'(BRAM_we), 0);
    chk("reset_bram_rst", 32'(BRAM_rst), 1);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_refresh", 32'(refresh), 0);
    rst = 1'b0;
    @(negedge BRAM_clk);
    chk("bram_rst_release", 32'(BRAM_rst), 0);

    run_table(0, 0, -1, 0, N + 20);
    chk("saw_w0", mem[0], 32'h0000_8000);
    chk("saw_w128", mem[128], 32'h0000_0000);
    chk("saw_w255", mem[255], 32'h0000_7F00);

    run_table(1, 4, -1, 0, N + 20);
    chk("sq_w0", mem[0], 32'h0000_07FF);
    chk("sq_w127", mem[127], 32'h0000_07FF);
    chk("sq_w128", mem[128], 32'h0000_F800);

    run_table(2, 0, -1, 0, N + 20);
    chk("tri_w0", mem[0], 32'h0000_8000);
    chk("tri_w64", mem[64], 32'h0000_0000);
    chk("tri_w128", mem[128], 32'h0000_7FFF);
    chk("tri_w255", mem[255], 32'h0000_81FF);

    run_table(3, 0, -1, 0, N + 20);
`ifdef WT_SINE_EN
    chk("sin_w0", mem[0], 32'h0000_0000);
    chk("sin_w64", mem[64], 32'h0000_7FFF);
    chk("sin_w128", mem[128], 32'h0000_0000);
    chk("sin_w192", mem[192], 32'h0000_8001);
`else
    chk("sin_w0", mem[0], 32'h0000_8000);
    chk("sin_w64", mem[64], 32'h0000_0000);
    chk("sin_w128", mem[128], 32'h0000_7FFF);
    chk("sin_w255", mem[255], 32'h0000_81FF);
`endif

    for (int r = 0; r < 4; r++)
      run_table(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), -1, 0, N + 20);

    // start + wave_sel change mid-table: ignored, no second refresh
    run_table(0, 0, 100, 0, 2 * N + 20);

    // reset at index 50, then a full table must still be written
    run_table(2, 3, 50, 1, N + 20);
    run_table(1, 7, -1, 0, N + 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
